// File: rtl/ann_weight_pkg.sv
// Shared definitions for the weight fetch path: default geometry of the
// weight BRAM and the fetch controller state encoding.
package ann_weight_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 5;
  localparam int DEF_N_WEIGHTS = 28;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } wf_state_e;

endpackage

// File: rtl/weight_fetch_fifo.sv
// Two-entry output FIFO for streamed weights. Entry "head" drives the
// consumer directly from a register, so data and last flag stay put while
// the consumer stalls. A push and a pop in the same cycle keep occupancy.
module weight_fetch_fifo #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_last,
  output logic              head_valid,
  output logic [1:0]        level_next
);

  logic [DATA_W-1:0] head_data_r;
  logic              head_last_r;
  logic [DATA_W-1:0] tail_data_r;
  logic              tail_last_r;
  logic [1:0]        count_r;
  logic              valid_r;
  logic              pop_s;
  logic [1:0]        count_next_s;

  assign pop_s = pop & valid_r;

  // Occupancy after this edge; the controller uses it to gate new reads.
  always_comb begin
    count_next_s = count_r + {1'b0, push} - {1'b0, pop_s};
  end

  // Entry storage: shift tail into head on pop, land pushes in the first free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_data_r <= {DATA_W{1'b0}};
      head_last_r <= 1'b0;
      tail_data_r <= {DATA_W{1'b0}};
      tail_last_r <= 1'b0;
      count_r     <= 2'd0;
      valid_r     <= 1'b0;
    end else begin
      count_r <= count_next_s;
      valid_r <= (count_next_s != 2'd0);
      case ({push, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_data_r <= push_data;
            head_last_r <= push_last;
          end else begin
            tail_data_r <= push_data;
            tail_last_r <= push_last;
          end
        end
        2'b01: begin
          head_data_r <= tail_data_r;
          head_last_r <= tail_last_r;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            head_data_r <= push_data;
            head_last_r <= push_last;
          end else begin
            head_data_r <= tail_data_r;
            head_last_r <= tail_last_r;
            tail_data_r <= push_data;
            tail_last_r <= push_last;
          end
        end
        default: begin
          head_data_r <= head_data_r;
        end
      endcase
    end
  end

  assign head_data  = head_data_r;
  assign head_last  = head_last_r;
  assign head_valid = valid_r;
  assign level_next = count_next_s;

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Weight fetch controller: on START, reads N_WEIGHTS words from a
// 1-cycle-latency BRAM in ascending order and streams them through a
// 2-entry FIFO with valid/ready handshake, W_LAST on the final word and a
// one-cycle DONE pulse once it has been accepted.
// Optional build macro WFETCH_CHKSUM_EN adds a CHKSUM output holding the
// modulo-2^DATA_W sum of the accepted words of the current fetch.
module weight_fetch_ctrl
  import ann_weight_pkg::*;
#(
  parameter int N_WEIGHTS = DEF_N_WEIGHTS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic [ADDR_W-1:0]        bram_addr,
  output logic                     bram_en,
  output logic                     bram_we,
  input  logic signed [DATA_W-1:0] bram_do,
  output logic signed [DATA_W-1:0] w_data,
  output logic                     w_valid,
  input  logic                     w_ready,
  output logic                     w_last,
  output logic                     busy,
  output logic                     done
`ifdef WFETCH_CHKSUM_EN
  ,
  output logic [DATA_W-1:0]        chksum
`endif
);

  // Issue counter is one bit wider so N_WEIGHTS = 2^ADDR_W is representable.
  localparam int                CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  N_CNT     = CNT_W'(N_WEIGHTS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WEIGHTS - 1);

  wf_state_e         state_r;
  wf_state_e         state_next_s;
  logic [CNT_W-1:0]  issued_r;
  logic [CNT_W-1:0]  issued_next_s;
  logic [ADDR_W-1:0] bram_addr_r;
  logic [ADDR_W-1:0] issue_addr_s;
  logic              bram_en_r;
  logic              issue_s;
  logic              busy_r;
  logic              done_r;
  logic              pop_s;
  logic              push_last_s;
  logic [1:0]        level_next_s;
  logic [DATA_W-1:0] fifo_data_s;

  assign pop_s       = w_valid & w_ready;
  assign push_last_s = (bram_addr_r == LAST_ADDR);

  weight_fetch_fifo #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (bram_en_r),
    .push_data  (bram_do),
    .push_last  (push_last_s),
    .pop        (pop_s),
    .head_data  (fifo_data_s),
    .head_last  (w_last),
    .head_valid (w_valid),
    .level_next (level_next_s)
  );

  // Next state and read-issue decision; a read is issued only if the FIFO
  // will still have a free slot for it once it lands.
  always_comb begin
    state_next_s  = state_r;
    issue_s       = 1'b0;
    issue_addr_s  = issued_r[ADDR_W-1:0];
    issued_next_s = issued_r + {{(CNT_W-1){1'b0}}, 1'b1};
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s  = ST_FETCH;
          issue_s       = 1'b1;
          issue_addr_s  = {ADDR_W{1'b0}};
          issued_next_s = {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (issued_r == N_CNT) begin
          state_next_s = ST_DRAIN;
        end else if (level_next_s < 2'd2) begin
          issue_s = 1'b1;
        end else begin
          issue_s = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (pop_s && w_last) begin
          state_next_s = ST_FIN;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_FIN: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, read port and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      issued_r    <= {CNT_W{1'b0}};
      bram_addr_r <= {ADDR_W{1'b0}};
      bram_en_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      bram_en_r <= issue_s;
      if (issue_s) begin
        bram_addr_r <= issue_addr_s;
        issued_r    <= issued_next_s;
      end
      busy_r <= (state_next_s == ST_FETCH) || (state_next_s == ST_DRAIN);
      done_r <= (state_next_s == ST_FIN);
    end
  end

  assign bram_addr = bram_addr_r;
  assign bram_en   = bram_en_r;
  assign bram_we   = 1'b0;
  assign w_data    = fifo_data_s;
  assign busy      = busy_r;
  assign done      = done_r;

`ifdef WFETCH_CHKSUM_EN
  logic [DATA_W-1:0] chksum_r;

  // Running sum of accepted words, restarted by every accepted START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chksum_r <= {DATA_W{1'b0}};
    end else if ((state_r == ST_IDLE) && start) begin
      chksum_r <= {DATA_W{1'b0}};
    end else if (pop_s) begin
      chksum_r <= chksum_r + fifo_data_s;
    end
  end

  assign chksum = chksum_r;
`endif

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Self-checking bench for weight_fetch_ctrl (28-word instance plus a
// 1-word instance). Expected stream is derived from the BRAM contents and
// the handshake rules: words in address order, one per accepted beat.
module tb_weight_fetch_ctrl;

  localparam int N  = 28;
  localparam int AW = 5;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 start, w_ready;
  logic [AW-1:0]        bram_addr;
  logic                 bram_en, bram_we;
  logic signed [DW-1:0] bram_do, w_data;
  logic                 w_valid, w_last, busy, done;

  logic                 start1, w_ready1;
  logic [AW-1:0]        bram_addr1;
  logic                 bram_en1, bram_we1;
  logic signed [DW-1:0] bram_do1, w_data1;
  logic                 w_valid1, w_last1, busy1, done1;
`ifdef WFETCH_CHKSUM_EN
  logic [DW-1:0]        chksum, chksum1;
`endif

  logic [DW-1:0] mem [0:31];
  logic [DW-1:0] mem1;

  int errors = 0;
  int checks = 0;

  weight_fetch_ctrl #(.N_WEIGHTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bram_addr(bram_addr),
    .bram_en(bram_en), .bram_we(bram_we), .bram_do(bram_do), .w_data(w_data),
    .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last), .busy(busy), .done(done)
`ifdef WFETCH_CHKSUM_EN
    , .chksum(chksum)
`endif
  );

  weight_fetch_ctrl #(.N_WEIGHTS(1), .ADDR_W(AW), .DATA_W(DW)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bram_addr(bram_addr1),
    .bram_en(bram_en1), .bram_we(bram_we1), .bram_do(bram_do1), .w_data(w_data1),
    .w_valid(w_valid1), .w_ready(w_ready1), .w_last(w_last1), .busy(busy1), .done(done1)
`ifdef WFETCH_CHKSUM_EN
    , .chksum(chksum1)
`endif
  );

  // BRAM models: data appears on the negedge of an enabled cycle.
  always @(negedge clk) begin
    if (bram_en) bram_do <= mem[bram_addr];
    if (bram_en1) bram_do1 <= mem1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ready_mode: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
  // restart_at >= 0: pulse START again when that many words were accepted.
  // reset_at >= 0: pull rst_n low when that many words were accepted.
  task automatic run_fetch(input int ready_mode, input int restart_at, input int reset_at);
    int            issued = 0;
    int            acc = 0;
    int            cyc = 0;
    int            done_cnt = 0;
    int            done_cyc = -1;
    int            last_acc_cyc = -10;
    int            first_valid = -1;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    logic          pulsed = 1'b0;
    logic          fin = 1'b0;
    logic [DW-1:0] sum = '0;
    while (!fin && cyc < 600) begin
      start = (cyc == 0);
      case (ready_mode)
        0: w_ready = 1'b1;
        1: w_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: w_ready = 1'($urandom_range(0, 1));
      endcase
      if (restart_at >= 0 && !pulsed && acc == restart_at && w_valid) begin
        start = 1'b1;
        pulsed = 1'b1;
        chk("busy_at_restart", 32'(busy), 32'd1);
      end
      if (cyc == 1) chk("busy_after_start", 32'(busy), 32'd1);
      chk("bram_we", 32'(bram_we), 32'd0);
      if (bram_en) begin
        chk("addr_order", 32'(bram_addr), 32'(issued));
        issued++;
        chk("outstanding_le2", 32'((issued - acc) <= 2), 32'd1);
        chk("issue_bound", 32'(issued <= N), 32'd1);
      end
      if (w_valid) begin
        if (first_valid < 0) begin
          first_valid = cyc;
          if (ready_mode == 0) chk("first_valid_latency", 32'(cyc), 32'd2);
        end
        if (prev_stall) begin
          chk("stall_data", 32'({w_data}), 32'(prev_data));
          chk("stall_last", 32'(w_last), 32'(prev_last));
        end
        chk("word_bound", 32'(acc < N), 32'd1);
        if (acc < N) begin
          chk("data", 32'({w_data}), 32'(mem[5'(acc)]));
          chk("last", 32'(w_last), 32'(acc == N - 1));
          if (ready_mode == 0) chk("sustain_cycle", 32'(cyc), 32'(acc + 2));
        end
        if (w_ready) begin
          if (acc < N) sum = sum + mem[5'(acc)];
          acc++;
          last_acc_cyc = cyc;
        end
        prev_stall = !w_ready;
        prev_data = w_data;
        prev_last = w_last;
      end else begin
        if (prev_stall) chk("stall_valid", 32'(w_valid), 32'd1);
        prev_stall = 1'b0;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_after_last", 32'(cyc), 32'(last_acc_cyc + 1));
        chk("done_word_count", 32'(acc), 32'(N));
`ifdef WFETCH_CHKSUM_EN
        chk("chksum", 32'(chksum), 32'(sum));
`endif
      end
      if (reset_at >= 0 && acc == reset_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_addr", 32'(bram_addr), 32'd0);
        chk("rst_en", 32'(bram_en), 32'd0);
        chk("rst_valid", 32'(w_valid), 32'd0);
        chk("rst_last", 32'(w_last), 32'd0);
        chk("rst_data", 32'({w_data}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        return;
      end
      if (done_cnt > 0 && cyc == done_cyc + 2) begin
        chk("busy_after_done", 32'(busy), 32'd0);
        fin = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    chk("completed_in_budget", 32'(fin), 32'd1);
    chk("done_single", 32'(done_cnt), 32'd1);
    chk("total_accepted", 32'(acc), 32'(N));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    w_ready = 1'b0;
    start1 = 1'b0;
    w_ready1 = 1'b0;
    mem1 = 16'hFFFB;
    for (int i = 0; i < 32; i++) mem[5'(i)] = 16'(i + 1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_addr", 32'(bram_addr), 32'd0);
    chk("reset_en", 32'(bram_en), 32'd0);
    chk("reset_valid", 32'(w_valid), 32'd0);
    chk("reset_last", 32'(w_last), 32'd0);
    chk("reset_data", 32'({w_data}), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
`ifdef WFETCH_CHKSUM_EN
    chk("reset_chksum", 32'(chksum), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_fetch(0, -1, -1);
`ifdef WFETCH_CHKSUM_EN
    chk("chksum_406", 32'(chksum), 32'h0196);
`endif
    run_fetch(1, -1, -1);
    run_fetch(0, 10, -1);
    run_fetch(0, -1, 15);
    @(posedge clk);
    #1;
    run_fetch(0, -1, -1);
    for (int i = 0; i < 32; i++) mem[5'(i)] = 16'($urandom);
    run_fetch(2, -1, -1);

    // Single-word instance.
    start1 = 1'b1;
    w_ready1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    chk("n1_busy", 32'(busy1), 32'd1);
    chk("n1_en", 32'(bram_en1), 32'd1);
    chk("n1_addr", 32'(bram_addr1), 32'd0);
    chk("n1_no_valid_yet", 32'(w_valid1), 32'd0);
    @(posedge clk);
    #1;
    chk("n1_valid", 32'(w_valid1), 32'd1);
    chk("n1_data", 32'({w_data1}), 32'h0000FFFB);
    chk("n1_last", 32'(w_last1), 32'd1);
    chk("n1_en_off", 32'(bram_en1), 32'd0);
    chk("n1_we", 32'(bram_we1), 32'd0);
    @(posedge clk);
    #1;
    chk("n1_done", 32'(done1), 32'd1);
    chk("n1_valid_clear", 32'(w_valid1), 32'd0);
`ifdef WFETCH_CHKSUM_EN
    chk("n1_chksum", 32'(chksum1), 32'h0000FFFB);
`endif
    @(posedge clk);
    #1;
    chk("n1_done_pulse", 32'(done1), 32'd0);
    chk("n1_idle", 32'(busy1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
